// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants, bundle widths and load-extraction helper
package riscv_pkg;

  localparam int XLEN = 32;

  // EX/MEM and MEM/WB bundle field widths
  localparam int REG_ADDR_W = 5;
  localparam int FUNCT3_W   = 3;
  localparam int BYTE_EN_W  = 4;

  // Load/store access size and signedness encodings
  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  // Selects the addressed byte/half of a memory word and extends it.
  // Halfword selection uses off[1] only, word ignores off entirely, so
  // misaligned low bits are dropped rather than crossing word lanes.
  function automatic logic [31:0] load_extract(
    input logic [FUNCT3_W-1:0] f3,
    input logic [1:0]          off,
    input logic [31:0]         word
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {off, 3'b000});
    h = 16'(word >> {off[1], 4'b0000});
    case (f3)
      F3_B:    load_extract = {{24{b[7]}}, b};
      F3_H:    load_extract = {{16{h[15]}}, h};
      F3_W:    load_extract = word;
      F3_BU:   load_extract = {24'h000000, b};
      F3_HU:   load_extract = {16'h0000, h};
      default: load_extract = 32'h00000000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem.sv
// rtl/data_mem.sv - word-organised data memory, byte-enable sync write, async read
module data_mem #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [0:DEPTH-1];

  // Byte-lane write; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - RV32I MEM stage (loads/stores, MEM/WB register); optional MISALIGN_TRAP_EN
module mem_access_stage #(
  parameter int DEPTH = 1024,
  parameter int XLEN  = riscv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_rs2_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_reg_write,
  input  logic            ex_mem_read,
  input  logic            ex_mem_write,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_write,
  output logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] wb_pc,
  output logic            wb_misalign
);

  import riscv_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [1:0]      off;
  logic [AW-1:0]   widx;
  logic [31:0]     rdata;
  logic [31:0]     load_data;
  logic [3:0]      be;
  logic [31:0]     wdata;
  logic            we;
  logic            misalign;

  logic            wb_valid_d, wb_valid_q;
  logic [4:0]      wb_rd_d, wb_rd_q;
  logic            wb_reg_write_d, wb_reg_write_q;
  logic [XLEN-1:0] wb_data_d, wb_data_q;
  logic [XLEN-1:0] wb_pc_d, wb_pc_q;
  logic            wb_misalign_d, wb_misalign_q;

  // Address bits above the memory size are dropped so accesses wrap
  logic unused_addr_hi;
  assign unused_addr_hi = ^ex_alu_result[XLEN-1:AW+2];

  assign off  = ex_alu_result[1:0];
  assign widx = ex_alu_result[AW+1:2];

`ifdef MISALIGN_TRAP_EN
  // Flag halfword/word accesses whose low address bits are not size-aligned
  always_comb begin
    misalign = 1'b0;
    if (ex_valid) begin
      if (ex_mem_write) begin
        case (ex_funct3)
          F3_H:    misalign = off[0];
          F3_W:    misalign = (off != 2'b00);
          default: misalign = 1'b0;
        endcase
      end else if (ex_mem_read) begin
        case (ex_funct3)
          F3_H, F3_HU: misalign = off[0];
          F3_W:        misalign = (off != 2'b00);
          default:     misalign = 1'b0;
        endcase
      end
    end
  end
`else
  assign misalign = 1'b0;
`endif

  // Byte enables and lane-replicated store data; the enable picks the lane
  always_comb begin
    be    = 4'b0000;
    wdata = ex_rs2_data[31:0];
    case (ex_funct3)
      F3_B: begin
        be    = 4'b0001 << off;
        wdata = {4{ex_rs2_data[7:0]}};
      end
      F3_H: begin
        be    = off[1] ? 4'b1100 : 4'b0011;
        wdata = {2{ex_rs2_data[15:0]}};
      end
      F3_W: begin
        be    = 4'b1111;
        wdata = ex_rs2_data[31:0];
      end
      default: begin
        be    = 4'b0000;
        wdata = ex_rs2_data[31:0];
      end
    endcase
  end

  assign we = rst & ex_valid & ex_mem_write & ~stall & ~misalign;

  data_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dmem (
    .clk_i   (clk),
    .we_i    (we),
    .be_i    (be),
    .addr_i  (widx),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  assign load_data = load_extract(ex_funct3, off, rdata);

  // Next MEM/WB bundle: stores and faults report the address, loads the aligned data
  always_comb begin
    wb_valid_d     = ex_valid;
    wb_rd_d        = ex_rd;
    wb_pc_d        = ex_pc;
    wb_misalign_d  = misalign;
    wb_reg_write_d = ex_valid & ex_reg_write & (ex_rd != 5'd0) & ~ex_mem_write & ~misalign;
    wb_data_d      = ex_alu_result;
    if (ex_mem_read && !ex_mem_write && !misalign) begin
      wb_data_d = XLEN'(load_data);
    end
  end

  // MEM/WB register: reset > flush > stall > normal
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q     <= 1'b0;
      wb_rd_q        <= '0;
      wb_reg_write_q <= 1'b0;
      wb_data_q      <= '0;
      wb_pc_q        <= '0;
      wb_misalign_q  <= 1'b0;
    end else if (flush) begin
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_misalign_q  <= 1'b0;
    end else if (!stall) begin
      wb_valid_q     <= wb_valid_d;
      wb_rd_q        <= wb_rd_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_data_q      <= wb_data_d;
      wb_pc_q        <= wb_pc_d;
      wb_misalign_q  <= wb_misalign_d;
    end
  end

  assign wb_valid     = wb_valid_q;
  assign wb_rd        = wb_rd_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_data      = wb_data_q;
  assign wb_pc        = wb_pc_q;
  assign wb_misalign  = wb_misalign_q;

endmodule
